// File: rtl/usb_tx_packet_sequencer.sv
// Purpose: sequences SYNC, PID, token/payload bytes, CRC16 and EOP from FWFT FIFOs into byte loads for the USB shifter.
// Latency: first tx_load (SYNC) two cycles after pkt_ready & !pid_empty in IDLE; loads then spaced at least BYTE_PERIOD cycles apart.
// Backpressure: tx_ready low stalls the current byte slot indefinitely; an empty payload FIFO at a due slot aborts the packet straight to EOP.
module usb_tx_packet_sequencer #(
   parameter int         BYTE_PERIOD = 8,
   parameter int         MAX_PAYLOAD = 64,
   parameter logic [7:0] SYNC_BYTE   = 8'h80,
   parameter int         IPG_CYCLES  = 16,
   parameter int         LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             pkt_ready,
   input  logic             pid_empty,
   input  logic [7:0]       pid_rdata,
   output logic             pid_pop,
   input  logic [LEN_W-1:0] data_len,
   input  logic [7:0]       nd_rdata,
   output logic             nd_pop,
   input  logic             data_empty,
   input  logic [7:0]       data_rdata,
   output logic             data_pop,
   input  logic [15:0]      crc_rdata,
   output logic             crc_pop,
   input  logic             tx_ready,
   output logic             tx_load,
   output logic [7:0]       tx_byte,
   output logic             eop_req,
   input  logic             eop_done,
   output logic             busy,
   output logic             pkt_done,
   output logic             err_pid,
   output logic             err_underrun
);

   localparam int PACE_W = $clog2(BYTE_PERIOD);
   localparam int CNT_W  = (LEN_W > 2) ? LEN_W : 2;
   localparam int GAP_W  = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   localparam logic [LEN_W-1:0]  MAX_LEN    = LEN_W'(MAX_PAYLOAD);
   localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(BYTE_PERIOD - 1);
   localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(IPG_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_SYNC, S_PID, S_ND, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_GAP
   } state_t;

   state_t             state, state_d;
   logic [7:0]         pid_q;
   logic [CNT_W-1:0]   cnt;
   logic [PACE_W-1:0]  pace;
   logic [GAP_W-1:0]   gap_cnt;
   logic               eop_sent;
   logic [7:0]         tx_byte_q;
   logic [7:0]         byte_d;
   logic [1:0]         nd_cnt;
   logic               fetch_is_data;
   logic               pid_ok;
   logic               slot;

   // Decode the PID at the FIFO head: token-field byte count and integrity/length check
   always_comb begin
      nd_cnt = 2'd0;
      casez (pid_rdata[3:0])
         4'b??01: nd_cnt = 2'd2;
         4'b0100: nd_cnt = 2'd2;
         4'b1000: nd_cnt = 2'd3;
         default: nd_cnt = 2'd0;
      endcase
      fetch_is_data = (pid_rdata[1:0] == 2'b11);
      pid_ok = (pid_rdata[7:4] == ~pid_rdata[3:0]) && (!fetch_is_data || (data_len <= MAX_LEN));
   end

   assign slot = (pace == '0) && tx_ready;

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_d;
   end

   // Next state and per-cycle strobes; tx_byte follows byte_d so it is valid with tx_load
   always_comb begin
      state_d      = state;
      byte_d       = tx_byte_q;
      tx_load      = 1'b0;
      pid_pop      = 1'b0;
      nd_pop       = 1'b0;
      data_pop     = 1'b0;
      crc_pop      = 1'b0;
      eop_req      = 1'b0;
      pkt_done     = 1'b0;
      err_pid      = 1'b0;
      err_underrun = 1'b0;
      case (state)
         S_IDLE: begin
            if (pkt_ready && !pid_empty) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (pid_ok) begin
               state_d = S_SYNC;
            end else begin
               pid_pop = 1'b1;
               err_pid = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_SYNC: begin
            if (slot) begin
               tx_load = 1'b1;
               byte_d  = SYNC_BYTE;
               state_d = S_PID;
            end
         end
         S_PID: begin
            if (slot) begin
               tx_load = 1'b1;
               byte_d  = pid_q;
               pid_pop = 1'b1;
               if (pid_q[1:0] == 2'b11) state_d = (cnt == '0) ? S_CRC_LO : S_DATA;
               else                     state_d = (cnt == '0) ? S_EOP : S_ND;
            end
         end
         S_ND: begin
            if (slot) begin
               tx_load = 1'b1;
               byte_d  = nd_rdata;
               nd_pop  = 1'b1;
               if (cnt == CNT_W'(1)) state_d = S_EOP;
            end
         end
         S_DATA: begin
            if (slot) begin
               if (data_empty) begin
                  // Payload ran dry: abandon the body and CRC, close the packet with EOP
                  err_underrun = 1'b1;
                  state_d      = S_EOP;
               end else begin
                  tx_load  = 1'b1;
                  byte_d   = data_rdata;
                  data_pop = 1'b1;
                  if (cnt == CNT_W'(1)) state_d = S_CRC_LO;
               end
            end
         end
         S_CRC_LO: begin
            if (slot) begin
               tx_load = 1'b1;
               byte_d  = crc_rdata[7:0];
               state_d = S_CRC_HI;
            end
         end
         S_CRC_HI: begin
            if (slot) begin
               tx_load = 1'b1;
               byte_d  = crc_rdata[15:8];
               crc_pop = 1'b1;
               state_d = S_EOP;
            end
         end
         S_EOP: begin
            if (!eop_sent) begin
               if (pace == '0) eop_req = 1'b1;
            end else if (eop_done) begin
               pkt_done = 1'b1;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign tx_byte = byte_d;
   assign busy    = (state != S_IDLE);

   // Datapath: latched PID, body byte counter, byte pacing, EOP handshake flag, gap timer
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pid_q     <= 8'h00;
         cnt       <= '0;
         pace      <= '0;
         gap_cnt   <= '0;
         eop_sent  <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         tx_byte_q <= byte_d;

         if (state == S_FETCH) begin
            pid_q <= pid_rdata;
            cnt   <= fetch_is_data ? CNT_W'(data_len) : CNT_W'(nd_cnt);
         end else if (tx_load && (state == S_ND || state == S_DATA)) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (tx_load)           pace <= PACE_RELOAD;
         else if (pace != '0)   pace <= pace - PACE_W'(1);

         if (state != S_EOP)    eop_sent <= 1'b0;
         else if (eop_req)      eop_sent <= 1'b1;

         if (pkt_done)                               gap_cnt <= GAP_RELOAD;
         else if (state == S_GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// Purpose: directed scenarios for the USB transmit packet sequencer with FIFO and shifter models.
// Latency: each scenario runs a bounded number of cycles, then compares logged events.
// Backpressure: tx_ready drop window and eop_done response are driven from the bench models.
module tb_usb_tx_packet_sequencer;
   localparam int LEN_W = 7;
   localparam int LOGN  = 512;

   logic             clk = 1'b0;
   logic             n_rst;
   logic             pkt_ready, pid_empty, pid_pop, nd_pop, data_empty, data_pop, crc_pop;
   logic [7:0]       pid_rdata, nd_rdata, data_rdata, tx_byte;
   logic [LEN_W-1:0] data_len;
   logic [15:0]      crc_rdata;
   logic             tx_ready, tx_load, eop_req, eop_done, busy, pkt_done, err_pid, err_underrun;

   usb_tx_packet_sequencer dut (
      .clk(clk), .n_rst(n_rst), .pkt_ready(pkt_ready), .pid_empty(pid_empty),
      .pid_rdata(pid_rdata), .pid_pop(pid_pop), .data_len(data_len), .nd_rdata(nd_rdata),
      .nd_pop(nd_pop), .data_empty(data_empty), .data_rdata(data_rdata), .data_pop(data_pop),
      .crc_rdata(crc_rdata), .crc_pop(crc_pop), .tx_ready(tx_ready), .tx_load(tx_load),
      .tx_byte(tx_byte), .eop_req(eop_req), .eop_done(eop_done), .busy(busy),
      .pkt_done(pkt_done), .err_pid(err_pid), .err_underrun(err_underrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [7:0]       pid_q[$];
   logic [LEN_W-1:0] len_q[$];
   logic [7:0]       nd_q[$];
   logic [7:0]       data_q[$];
   logic [15:0]      crc_q[$];

   int         cyc;
   logic [7:0] ld_byte[$];
   int         ld_cyc[$];
   int         pid_pops, nd_pops, data_pops, crc_pops, pid_pop_cyc, crc_pop_cyc;
   int         eop_cnt, eop_cyc, eop_last, done_cnt, done_cyc;
   int         errp_cnt, errp_cyc, erru_cnt, erru_cyc, orphan;
   bit         drop_en;
   int         drop_start;
   bit         busy_log[LOGN];

   task automatic clear_queues();
      pid_q.delete(); len_q.delete(); nd_q.delete(); data_q.delete(); crc_q.delete();
   endtask

   task automatic clear_log();
      ld_byte.delete(); ld_cyc.delete();
      pid_pops = 0; nd_pops = 0; data_pops = 0; crc_pops = 0; pid_pop_cyc = -1; crc_pop_cyc = -1;
      eop_cnt = 0; eop_cyc = -1; eop_last = -1000; done_cnt = 0; done_cyc = -1;
      errp_cnt = 0; errp_cyc = -1; erru_cnt = 0; erru_cyc = -1; orphan = 0;
      drop_en = 1'b0; drop_start = -1; cyc = 0;
      for (int i = 0; i < LOGN; i++) busy_log[i] = 1'b0;
   endtask

   task automatic drive_inputs();
      pid_empty  = (pid_q.size() == 0);
      pid_rdata  = (pid_q.size() > 0) ? pid_q[0] : 8'h00;
      data_len   = (len_q.size() > 0) ? len_q[0] : '0;
      nd_rdata   = (nd_q.size() > 0) ? nd_q[0] : 8'h00;
      data_empty = (data_q.size() == 0);
      data_rdata = (data_q.size() > 0) ? data_q[0] : 8'h00;
      crc_rdata  = (crc_q.size() > 0) ? crc_q[0] : 16'h0000;
      tx_ready   = !(drop_en && drop_start >= 0 && cyc >= drop_start && cyc < drop_start + 5);
      eop_done   = (cyc == eop_last + 3);
   endtask

   // One clock: sample and log outputs at negedge, retire popped FIFO heads after posedge
   task automatic step();
      bit p_pid, p_nd, p_data, p_crc;
      @(negedge clk);
      if (cyc < LOGN) busy_log[cyc] = busy;
      p_pid = pid_pop; p_nd = nd_pop; p_data = data_pop; p_crc = crc_pop;
      if (tx_load) begin
         ld_byte.push_back(tx_byte);
         ld_cyc.push_back(cyc);
         if (drop_en && tx_byte == 8'hAA && drop_start < 0) drop_start = cyc + 8;
      end
      if (pid_pop) begin pid_pops++; pid_pop_cyc = cyc; if (!tx_load && !err_pid) orphan++; end
      if (nd_pop) begin nd_pops++; if (!tx_load) orphan++; end
      if (data_pop) begin data_pops++; if (!tx_load) orphan++; end
      if (crc_pop) begin crc_pops++; crc_pop_cyc = cyc; if (!tx_load) orphan++; end
      if (eop_req) begin if (eop_cnt == 0) eop_cyc = cyc; eop_cnt++; eop_last = cyc; end
      if (pkt_done) begin if (done_cnt == 0) done_cyc = cyc; done_cnt++; end
      if (err_pid) begin errp_cnt++; errp_cyc = cyc; end
      if (err_underrun) begin erru_cnt++; erru_cyc = cyc; end
      @(posedge clk); #1;
      if (p_pid && pid_q.size() > 0) begin void'(pid_q.pop_front()); void'(len_q.pop_front()); end
      if (p_nd && nd_q.size() > 0) void'(nd_q.pop_front());
      if (p_data && data_q.size() > 0) void'(data_q.pop_front());
      if (p_crc && crc_q.size() > 0) void'(crc_q.pop_front());
      cyc++;
      drive_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [63:0] loads_packed();
      logic [63:0] v = 64'h0;
      foreach (ld_byte[i]) v = {v[55:0], ld_byte[i]};
      return v;
   endfunction

   function automatic bit spacing_ok(input int skip);
      for (int i = 0; i + 1 < ld_cyc.size(); i++)
         if (i != skip && (ld_cyc[i+1] - ld_cyc[i]) != 8) return 1'b0;
      return 1'b1;
   endfunction

   task automatic start_pkt();
      clear_log();
      pkt_ready = 1'b1;
      drive_inputs();
   endtask

   task automatic test_reset();
      n_rst = 1'b0; pkt_ready = 1'b0;
      clear_queues(); clear_log(); drive_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if ({pid_pop, nd_pop, data_pop, crc_pop, tx_load, eop_req, busy, pkt_done, err_pid, err_underrun} !== 10'b0) begin
         failures++; $display("FAIL reset_outputs: got %b expected 0", {pid_pop, nd_pop, data_pop, crc_pop, tx_load, eop_req, busy, pkt_done, err_pid, err_underrun});
      end
      checks++;
      if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
      @(posedge clk); #1;
      n_rst = 1'b1;
   endtask

   task automatic test_reset_mid_packet();
      clear_queues();
      pid_q.push_back(8'hC3); len_q.push_back(7'd3);
      data_q = '{8'hAA, 8'hBB, 8'hCC}; crc_q.push_back(16'h1234);
      start_pkt();
      run(30);
      checks++;
      if (loads_packed() !== 64'h80C3AABB) begin failures++; $display("FAIL midrst_preloads: got %h expected 80c3aabb", loads_packed()); end
      n_rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({pid_pop, nd_pop, data_pop, crc_pop, tx_load, eop_req, busy, pkt_done, err_pid, err_underrun, tx_byte} !== 18'b0) begin
         failures++; $display("FAIL midrst_outputs: got %h expected 0", {pid_pop, nd_pop, data_pop, crc_pop, tx_load, eop_req, busy, pkt_done, err_pid, err_underrun, tx_byte});
      end
      @(posedge clk); #1;
      pkt_ready = 1'b0; clear_queues(); clear_log(); drive_inputs();
      n_rst = 1'b1;
      run(40);
      checks++;
      if (eop_cnt != 0) begin failures++; $display("FAIL midrst_no_eop: got %0d eop_req expected 0", eop_cnt); end
      checks++;
      if (ld_byte.size() != 0) begin failures++; $display("FAIL midrst_no_load: got %0d loads expected 0", ld_byte.size()); end
   endtask

   task automatic test_ack();
      clear_queues();
      pid_q.push_back(8'hD2); len_q.push_back(7'd0);
      start_pkt();
      run(60);
      checks++;
      if (ld_byte.size() != 2 || loads_packed() !== 64'h80D2) begin failures++; $display("FAIL ack_loads: got %h expected 80d2", loads_packed()); end
      if (ld_cyc.size() == 2) begin
         checks++;
         if (ld_cyc[0] != 2) begin failures++; $display("FAIL ack_first_load: got cycle %0d expected 2", ld_cyc[0]); end
         checks++;
         if (ld_cyc[1] != ld_cyc[0] + 8) begin failures++; $display("FAIL ack_spacing: got %0d expected %0d", ld_cyc[1], ld_cyc[0] + 8); end
         checks++;
         if (pid_pop_cyc != ld_cyc[0] + 8) begin failures++; $display("FAIL ack_pid_pop: got %0d expected %0d", pid_pop_cyc, ld_cyc[0] + 8); end
         checks++;
         if (eop_cyc != ld_cyc[0] + 16) begin failures++; $display("FAIL ack_eop_req: got %0d expected %0d", eop_cyc, ld_cyc[0] + 16); end
      end
      checks++;
      if (nd_pops + data_pops + crc_pops != 0) begin failures++; $display("FAIL ack_no_pops: got %0d expected 0", nd_pops + data_pops + crc_pops); end
      checks++;
      if (done_cnt != 1 || busy_log[50] !== 1'b0) begin failures++; $display("FAIL ack_done_idle: got done=%0d busy=%0b expected 1/0", done_cnt, busy_log[50]); end
   endtask

   task automatic test_token();
      clear_queues();
      pid_q.push_back(8'h69); len_q.push_back(7'd0); nd_q = '{8'h01, 8'h10};
      start_pkt();
      run(100);
      checks++;
      if (ld_byte.size() != 4 || loads_packed() !== 64'h80690110) begin failures++; $display("FAIL in_loads: got %h expected 80690110", loads_packed()); end
      checks++;
      if (!spacing_ok(-1)) begin failures++; $display("FAIL in_spacing: got irregular expected 8"); end
      checks++;
      if (nd_pops != 2 || orphan != 0) begin failures++; $display("FAIL in_nd_pops: got %0d/%0d expected 2/0", nd_pops, orphan); end
      checks++;
      if (done_cnt != 1 || done_cyc != eop_cyc + 3) begin failures++; $display("FAIL in_pkt_done: got %0d@%0d expected 1@%0d", done_cnt, done_cyc, eop_cyc + 3); end

      clear_queues();
      pid_q.push_back(8'hB4); len_q.push_back(7'd0); nd_q = '{8'h5A, 8'hA5};
      start_pkt();
      run(100);
      checks++;
      if (ld_byte.size() != 4 || loads_packed() !== 64'h80B45AA5 || nd_pops != 2) begin failures++; $display("FAIL ping_loads: got %h expected 80b45aa5", loads_packed()); end

      clear_queues();
      pid_q.push_back(8'h78); len_q.push_back(7'd0); nd_q = '{8'h11, 8'h22, 8'h33};
      start_pkt();
      run(110);
      checks++;
      if (ld_byte.size() != 5 || loads_packed() !== 64'h8078112233 || nd_pops != 3) begin failures++; $display("FAIL split_loads: got %h expected 8078112233", loads_packed()); end
   endtask

   task automatic test_data();
      clear_queues();
      pid_q.push_back(8'hC3); len_q.push_back(7'd3);
      data_q = '{8'hAA, 8'hBB, 8'hCC}; crc_q.push_back(16'h1234);
      start_pkt();
      drop_en = 1'b1;
      run(120);
      checks++;
      if (ld_byte.size() != 7 || loads_packed() !== 64'h80C3AABBCC3412) begin failures++; $display("FAIL data0_loads: got %h expected 80c3aabbcc3412", loads_packed()); end
      if (ld_cyc.size() == 7) begin
         checks++;
         if (ld_cyc[3] - ld_cyc[2] != 13) begin failures++; $display("FAIL data0_stall: got %0d expected 13", ld_cyc[3] - ld_cyc[2]); end
         checks++;
         if (!spacing_ok(2)) begin failures++; $display("FAIL data0_spacing: got irregular expected 8"); end
         checks++;
         if (crc_pop_cyc != ld_cyc[6]) begin failures++; $display("FAIL data0_crc_pop_cyc: got %0d expected %0d", crc_pop_cyc, ld_cyc[6]); end
      end
      checks++;
      if (data_pops != 3 || crc_pops != 1 || orphan != 0) begin failures++; $display("FAIL data0_pops: got %0d/%0d/%0d expected 3/1/0", data_pops, crc_pops, orphan); end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL data0_done: got %0d expected 1", done_cnt); end

      clear_queues();
      pid_q.push_back(8'h4B); len_q.push_back(7'd0); crc_q.push_back(16'hBEEF);
      start_pkt();
      run(80);
      checks++;
      if (ld_byte.size() != 4 || loads_packed() !== 64'h804BEFBE) begin failures++; $display("FAIL zlen_loads: got %h expected 804befbe", loads_packed()); end
      checks++;
      if (data_pops != 0 || crc_pops != 1) begin failures++; $display("FAIL zlen_pops: got %0d/%0d expected 0/1", data_pops, crc_pops); end
   endtask

   task automatic test_pid_error();
      clear_queues();
      pid_q.push_back(8'hC4); len_q.push_back(7'd0);
      start_pkt();
      run(20);
      checks++;
      if (errp_cnt != 1 || errp_cyc != 1 || pid_pops != 1) begin failures++; $display("FAIL badpid_err: got %0d@%0d pops=%0d expected 1@1 pops=1", errp_cnt, errp_cyc, pid_pops); end
      checks++;
      if (ld_byte.size() != 0 || busy_log[2] !== 1'b0) begin failures++; $display("FAIL badpid_idle: got loads=%0d busy=%0b expected 0/0", ld_byte.size(), busy_log[2]); end

      clear_queues();
      pid_q.push_back(8'h4B); len_q.push_back(7'd65);
      start_pkt();
      run(20);
      checks++;
      if (errp_cnt != 1 || pid_pops != 1 || ld_byte.size() != 0 || busy_log[2] !== 1'b0) begin
         failures++; $display("FAIL badlen_err: got err=%0d pops=%0d loads=%0d expected 1/1/0", errp_cnt, pid_pops, ld_byte.size());
      end

      clear_queues();
      pid_q.push_back(8'h4B); len_q.push_back(7'd64); crc_q.push_back(16'h0000);
      start_pkt();
      run(60);
      checks++;
      if (errp_cnt != 0 || erru_cnt != 1 || loads_packed() !== 64'h804B) begin
         failures++; $display("FAIL maxlen_accept: got err=%0d under=%0d loads=%h expected 0/1/804b", errp_cnt, erru_cnt, loads_packed());
      end
   endtask

   task automatic test_underrun();
      clear_queues();
      pid_q.push_back(8'h4B); len_q.push_back(7'd4);
      data_q = '{8'h11, 8'h22}; crc_q.push_back(16'h5566);
      start_pkt();
      run(80);
      checks++;
      if (ld_byte.size() != 4 || loads_packed() !== 64'h804B1122) begin failures++; $display("FAIL under_loads: got %h expected 804b1122", loads_packed()); end
      if (ld_cyc.size() == 4) begin
         checks++;
         if (erru_cnt != 1 || erru_cyc != ld_cyc[3] + 8) begin failures++; $display("FAIL under_pulse: got %0d@%0d expected 1@%0d", erru_cnt, erru_cyc, ld_cyc[3] + 8); end
      end
      checks++;
      if (eop_cyc != erru_cyc + 1) begin failures++; $display("FAIL under_eop: got %0d expected %0d", eop_cyc, erru_cyc + 1); end
      checks++;
      if (crc_pops != 0 || data_pops != 2 || done_cnt != 1) begin failures++; $display("FAIL under_pops: got crc=%0d data=%0d done=%0d expected 0/2/1", crc_pops, data_pops, done_cnt); end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      pid_q = '{8'hD2, 8'h5A}; len_q = '{7'd0, 7'd0};
      start_pkt();
      run(150);
      checks++;
      if (ld_byte.size() != 4 || loads_packed() !== 64'h80D2805A) begin failures++; $display("FAIL b2b_loads: got %h expected 80d2805a", loads_packed()); end
      if (ld_cyc.size() == 4) begin
         checks++;
         if (ld_cyc[2] != done_cyc + 19) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", ld_cyc[2], done_cyc + 19); end
      end
      checks++;
      if (done_cnt != 2 || pid_pops != 2) begin failures++; $display("FAIL b2b_done: got %0d/%0d expected 2/2", done_cnt, pid_pops); end
   endtask

   initial begin
      test_reset();
      test_reset_mid_packet();
      test_ack();
      test_token();
      test_data();
      test_pid_error();
      test_underrun();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
